// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 bit mux: steps the select through the enabled channels in
// ascending order, samples the mux output after a dwell and publishes an 8-bit snapshot.
module mux8_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       chan_mask,
    input  logic             mux_out,
    output logic [2:0]       sel,
    output logic             busy,
    output logic [7:0]       snap_data,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [CNT_W-1:0] scan_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t           r_state;
    logic [2:0]       r_sel;
    logic             r_busy;
    logic [7:0]       r_snap_data;
    logic             r_snap_valid;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [7:0]       r_mask_q;
    logic [7:0]       r_shadow;
    logic [3:0]       r_dwell_cnt;

    logic             w_accept;
    logic [3:0]       w_first;
    logic [3:0]       w_next;
    logic             w_dwell_end;
    logic [7:0]       w_shadow_upd;

    // Returns {found, index} of the lowest set bit of m.
    function automatic logic [3:0] lowest_set(input logic [7:0] m);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) begin
                res = {1'b1, 3'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Start acceptance, channel lookahead and the shadow word with the current sample merged in.
    always_comb begin
        w_accept            = start && (r_state == ST_IDLE) && (!r_snap_valid || snap_ready);
        w_first             = lowest_set(chan_mask);
        w_next              = lowest_set(r_mask_q & (8'hFE << r_sel));
        w_dwell_end         = (r_dwell_cnt == DWELL_LAST);
        w_shadow_upd        = r_shadow;
        w_shadow_upd[r_sel] = mux_out;
    end

    // Scan FSM with all outputs registered; the last sample publishes the snapshot directly
    // so it appears the cycle after the final dwell, and DONE only publishes empty-mask scans.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= 3'd0;
            r_busy       <= 1'b0;
            r_snap_data  <= 8'h00;
            r_snap_valid <= 1'b0;
            r_scan_cnt   <= '0;
            r_mask_q     <= 8'h00;
            r_shadow     <= 8'h00;
            r_dwell_cnt  <= 4'd0;
        end else begin
            if (r_snap_valid && snap_ready) begin
                r_snap_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mask_q    <= chan_mask;
                        r_shadow    <= 8'h00;
                        r_dwell_cnt <= 4'd0;
                        if (w_first[3]) begin
                            r_state <= ST_DWELL;
                            r_sel   <= w_first[2:0];
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DWELL: begin
                    if (w_dwell_end) begin
                        r_shadow    <= w_shadow_upd;
                        r_dwell_cnt <= 4'd0;
                        if (w_next[3]) begin
                            r_sel <= w_next[2:0];
                        end else begin
                            r_sel        <= 3'd0;
                            r_busy       <= 1'b0;
                            r_snap_data  <= w_shadow_upd;
                            r_snap_valid <= 1'b1;
                            r_scan_cnt   <= r_scan_cnt + CNT_W'(1);
                            r_state      <= ST_DONE;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_sel   <= 3'd0;
                    r_busy  <= 1'b0;
                    if (r_mask_q == 8'h00) begin
                        r_snap_data  <= r_shadow;
                        r_snap_valid <= 1'b1;
                        r_scan_cnt   <= r_scan_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= 3'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign busy       = r_busy;
    assign snap_data  = r_snap_data;
    assign snap_valid = r_snap_valid;
    assign scan_cnt   = r_scan_cnt;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: two instances (DWELL=2 and DWELL=3) against a plan-based reference
// model, directed scenarios followed by randomized traffic.
module tb_mux8_scan_ctrl;

    logic       clk        = 1'b0;
    logic       clk_en     = 1'b0;
    logic       rst        = 1'b1;
    logic [1:0] start_v    = 2'b00;
    logic [7:0] chan_mask  = 8'h00;
    logic [7:0] mux_in     = 8'h00;
    logic       snap_ready = 1'b0;

    logic [2:0] sel_o   [2];
    logic       busy_o  [2];
    logic [7:0] data_o  [2];
    logic       valid_o [2];
    logic [7:0] cnt_o   [2];
    logic       mux_o   [2];

    // The 8:1 mux in front of each instance.
    assign mux_o[0] = mux_in[sel_o[0]];
    assign mux_o[1] = mux_in[sel_o[1]];

    mux8_scan_ctrl #(.DWELL(2), .CNT_W(8)) u_dut_d2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .chan_mask(chan_mask), .mux_out(mux_o[0]),
        .sel(sel_o[0]), .busy(busy_o[0]), .snap_data(data_o[0]), .snap_valid(valid_o[0]),
        .snap_ready(snap_ready), .scan_cnt(cnt_o[0]));

    mux8_scan_ctrl #(.DWELL(3), .CNT_W(8)) u_dut_d3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .chan_mask(chan_mask), .mux_out(mux_o[1]),
        .sel(sel_o[1]), .busy(busy_o[1]), .snap_data(data_o[1]), .snap_valid(valid_o[1]),
        .snap_ready(snap_ready), .scan_cnt(cnt_o[1]));

    always #5 if (clk_en) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected outputs for the current cycle plus the planned sel sequence.
    int         dw [2] = '{2, 3};
    int         m_sel [2], m_busy [2], m_valid [2], m_data [2], m_cnt [2];
    bit         m_act [2], m_done [2];
    int         m_len [2], m_pos [2];
    logic [7:0] m_shadow [2];
    int         plan_ch  [2][128];
    bit         plan_smp [2][128];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sel[d] = 0; m_busy[d] = 0; m_valid[d] = 0; m_data[d] = 0; m_cnt[d] = 0;
            m_act[d] = 1'b0; m_done[d] = 1'b0; m_len[d] = 0; m_pos[d] = 0; m_shadow[d] = 8'h00;
        end
    endtask

    // Advance one instance's model across the coming rising edge using the inputs now driven.
    task automatic model_step(input int d);
        int nsel, nbusy, nvalid, ndata, ncnt, c;
        bit nact, ndone, acc;
        nvalid = (m_valid[d] != 0 && snap_ready) ? 0 : m_valid[d];
        nsel = 0; nbusy = 0; ndata = m_data[d]; ncnt = m_cnt[d]; nact = 1'b0; ndone = 1'b0;
        acc = start_v[d] && !m_act[d] && !m_done[d] && (m_valid[d] == 0 || snap_ready);
        if (m_act[d]) begin
            c = plan_ch[d][m_pos[d]];
            if (plan_smp[d][m_pos[d]]) m_shadow[d][c] = mux_in[c];
            m_pos[d]++;
            if (m_pos[d] == m_len[d]) begin
                nvalid = 1; ndata = m_shadow[d]; ncnt = (m_cnt[d] + 1) % 256; ndone = 1'b1;
            end else begin
                nact = 1'b1; nsel = plan_ch[d][m_pos[d]]; nbusy = 1;
            end
        end else if (m_done[d]) begin
            if (m_len[d] == 0) begin
                nvalid = 1; ndata = 0; ncnt = (m_cnt[d] + 1) % 256;
            end
        end else if (acc) begin
            m_len[d] = 0; m_pos[d] = 0; m_shadow[d] = 8'h00;
            for (int ch = 0; ch < 8; ch++) begin
                if (chan_mask[ch]) begin
                    for (int k = 1; k <= dw[d]; k++) begin
                        plan_ch[d][m_len[d]]  = ch;
                        plan_smp[d][m_len[d]] = (k == dw[d]);
                        m_len[d]++;
                    end
                end
            end
            if (m_len[d] == 0) ndone = 1'b1;
            else begin
                nact = 1'b1; nsel = plan_ch[d][0]; nbusy = 1;
            end
        end
        m_sel[d] = nsel; m_busy[d] = nbusy; m_valid[d] = nvalid; m_data[d] = ndata;
        m_cnt[d] = ncnt; m_act[d] = nact; m_done[d] = ndone;
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_sel", d),   sel_o[d],   m_sel[d]);
            chk($sformatf("d%0d_busy", d),  busy_o[d],  m_busy[d]);
            chk($sformatf("d%0d_valid", d), valid_o[d], m_valid[d]);
            chk($sformatf("d%0d_data", d),  data_o[d],  m_data[d]);
            chk($sformatf("d%0d_cnt", d),   cnt_o[d],   m_cnt[d]);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, step the model, check at the next falling edge.
    task automatic cycle(input logic [1:0] st, input logic [7:0] mk, input logic [7:0] mi,
                         input logic rdy);
        start_v = st; chan_mask = mk; mux_in = mi; snap_ready = rdy;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_sel"},   sel_o[d],   32'd0);
            chk({tag, "_busy"},  busy_o[d],  32'd0);
            chk({tag, "_valid"}, valid_o[d], 32'd0);
            chk({tag, "_data"},  data_o[d],  32'd0);
            chk({tag, "_cnt"},   cnt_o[d],   32'd0);
        end
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_values("rst_init");
        rst = 1'b0;
        #1;
        clk_en = 1'b1;
        @(negedge clk);
        compare_all();

        // Full scan on DWELL=2: sel 0,0,1,1,...,7,7 then snapshot 0xA6.
        cycle(2'b01, 8'hFF, 8'hA6, 1'b1);
        chk("full_sel", sel_o[0], 32'd0);
        for (int i = 1; i < 16; i++) begin
            cycle(2'b00, 8'h00, 8'hA6, 1'b1);
            chk("full_sel", sel_o[0], 32'(i / 2));
        end
        cycle(2'b00, 8'h00, 8'hA6, 1'b1);
        chk("full_valid", valid_o[0], 32'd1);
        chk("full_data", data_o[0], 32'hA6);
        chk("full_cnt", cnt_o[0], 32'd1);
        chk("full_sel_idle", sel_o[0], 32'd0);
        cycle(2'b00, 8'h00, 8'hA6, 1'b1);
        chk("full_valid_drop", valid_o[0], 32'd0);

        // Sparse mask on DWELL=3 with every input high: only bits 0 and 7 may be set.
        cycle(2'b10, 8'h81, 8'hFF, 1'b1);
        chk("sparse_sel", sel_o[1], 32'd0);
        for (int i = 1; i < 6; i++) begin
            cycle(2'b00, 8'h00, 8'hFF, 1'b1);
            chk("sparse_sel", sel_o[1], (i < 3) ? 32'd0 : 32'd7);
        end
        cycle(2'b00, 8'h00, 8'hFF, 1'b1);
        chk("sparse_valid", valid_o[1], 32'd1);
        chk("sparse_data", data_o[1], 32'h81);
        for (int i = 0; i < 3; i++) cycle(2'b00, 8'h00, 8'h00, 1'b1);

        // Empty mask: never busy, snapshot of zero two cycles after acceptance.
        cycle(2'b01, 8'h00, 8'hFF, 1'b1);
        chk("zero_busy", busy_o[0], 32'd0);
        chk("zero_valid_early", valid_o[0], 32'd0);
        cycle(2'b00, 8'h00, 8'hFF, 1'b1);
        chk("zero_valid", valid_o[0], 32'd1);
        chk("zero_data", data_o[0], 32'h00);
        chk("zero_cnt", cnt_o[0], 32'd2);
        for (int i = 0; i < 3; i++) cycle(2'b00, 8'h00, 8'h00, 1'b1);

        // Backpressure: snapshot held, starts ignored, then transfer and start together.
        cycle(2'b01, 8'h05, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b00, 8'h00, 8'hFF, 1'b0);
        chk("bp_valid", valid_o[0], 32'd1);
        chk("bp_data", data_o[0], 32'h05);
        for (int i = 0; i < 10; i++) begin
            cycle((i % 2 == 0) ? 2'b01 : 2'b00, 8'hFF, 8'hFF, 1'b0);
            chk("bp_busy_hold", busy_o[0], 32'd0);
            chk("bp_valid_hold", valid_o[0], 32'd1);
            chk("bp_data_hold", data_o[0], 32'h05);
        end
        cycle(2'b01, 8'h02, 8'hFF, 1'b1);
        chk("bp_xfer_valid", valid_o[0], 32'd0);
        chk("bp_new_busy", busy_o[0], 32'd1);
        chk("bp_new_sel", sel_o[0], 32'd1);
        cycle(2'b00, 8'h00, 8'hFF, 1'b1);
        cycle(2'b00, 8'h00, 8'hFF, 1'b1);
        chk("bp_new_valid", valid_o[0], 32'd1);
        chk("bp_new_data", data_o[0], 32'h02);
        for (int i = 0; i < 3; i++) cycle(2'b00, 8'h00, 8'h00, 1'b1);

        // Reset at T+5 of a full scan with the clock stopped.
        cycle(2'b01, 8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) cycle(2'b00, 8'h00, 8'hFF, 1'b1);
        clk_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        #1;
        rst = 1'b0;
        start_v = 2'b00;
        clk_en = 1'b1;
        @(negedge clk);
        compare_all();
        for (int i = 0; i < 20; i++) begin
            cycle(2'b00, 8'h00, 8'hFF, 1'b1);
            chk("rst_no_valid", valid_o[0], 32'd0);
        end
        cycle(2'b01, 8'hFF, 8'h3C, 1'b1);
        for (int i = 0; i < 16; i++) cycle(2'b00, 8'h00, 8'h3C, 1'b1);
        chk("fresh_valid", valid_o[0], 32'd1);
        chk("fresh_data", data_o[0], 32'h3C);
        chk("fresh_cnt", cnt_o[0], 32'd1);

        // Randomized traffic on both instances, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] st;
            logic [7:0] mk;
            st[0] = ($urandom_range(0, 3) == 0);
            st[1] = ($urandom_range(0, 3) == 0);
            mk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle(st, mk, 8'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
